// File: rtl/fp_normalize_round.sv
// fp_normalize_round: two-stage normalizer (leading-one shift) and RNE rounder/packer
// with valid/ready handshakes on both sides.
module leading_one_detector #(
  parameter int W  = 28,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < W; i++) pos_o = vec_i[i] ? PW'(i) : pos_o;
  end
  assign zero_o = ~|vec_i;
endmodule

module fp_normalize_round #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  localparam int SIG_WIDTH = MANT_WIDTH + 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sign,
  input  logic [EXP_WIDTH+1:0]            in_exp,
  input  logic [SIG_WIDTH-1:0]            in_sig,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   out_result,
  output logic [3:0]                      out_flags
);
  localparam int PW = $clog2(SIG_WIDTH);
  localparam int XW = EXP_WIDTH + PW + 3;
  localparam int RW = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(0);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);

  logic [PW-1:0] lead_pos, shamt;
  logic sig_zero, carry_in, s2_ready, s1_adv;
  logic [SIG_WIDTH-3:0] norm_sig;
  logic signed [XW-1:0] exp_ext, norm_exp;
  logic s1_valid_q, s1_sign_q, s1_zero_q;
  logic signed [XW-1:0] s1_exp_q, exp_rnd;
  logic [SIG_WIDTH-3:0] s1_sig_q;
  logic [MANT_WIDTH:0] mant_sum;
  logic rnd_up, inexact, uflow, oflow;
  logic out_valid_q;
  logic [RW-1:0] result_d, result_q;
  logic [3:0] flags_d, flags_q;

  leading_one_detector #(.W(SIG_WIDTH)) u_lod (
    .vec_i (in_sig),
    .pos_o (lead_pos),
    .zero_o(sig_zero)
  );

  // Hidden bit is dropped from storage: after normalization it is always 1 (or the word is zero).
  assign carry_in = lead_pos == PW'(SIG_WIDTH - 1);
  assign shamt    = PW'(SIG_WIDTH - 2) - lead_pos;
  assign exp_ext  = {{(XW-EXP_WIDTH-2){in_exp[EXP_WIDTH+1]}}, in_exp};
  assign norm_sig = carry_in ? {in_sig[SIG_WIDTH-2:2], in_sig[1] | in_sig[0]} : in_sig[SIG_WIDTH-3:0] << shamt;
  assign norm_exp = carry_in ? exp_ext + EXP_ONE : exp_ext - XW'(shamt);

  assign s2_ready = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  always_ff @(posedge clk) begin
    if (rst) s1_valid_q <= 1'b0;
    else if (in_ready) s1_valid_q <= in_valid;
    if (in_valid && in_ready) begin
      s1_sign_q <= in_sign;
      s1_zero_q <= sig_zero;
      s1_exp_q  <= norm_exp;
      s1_sig_q  <= norm_sig;
    end
  end

  assign rnd_up   = s1_sig_q[2] & (s1_sig_q[1] | s1_sig_q[0] | s1_sig_q[3]);
  assign inexact  = |s1_sig_q[2:0];
  assign mant_sum = {1'b0, s1_sig_q[SIG_WIDTH-3:3]} + (MANT_WIDTH+1)'(rnd_up);
  assign exp_rnd  = s1_exp_q + XW'(mant_sum[MANT_WIDTH]);
  assign uflow    = s1_exp_q <= EXP_MIN;
  assign oflow    = exp_rnd >= EXP_MAX;
  assign result_d = (s1_zero_q || uflow) ? {s1_sign_q, {(RW-1){1'b0}}} :
                    oflow ? {s1_sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
                    {s1_sign_q, exp_rnd[EXP_WIDTH-1:0], mant_sum[MANT_WIDTH-1:0]};
  assign flags_d  = s1_zero_q ? 4'b0001 : uflow ? 4'b0111 : oflow ? 4'b1010 : {2'b00, inexact, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed vector table, randomized backpressured stream against an
// arithmetic RNE model, and a mid-stream reset sequence.
module tb_fp_normalize_round;
  localparam int EW = 8;
  localparam int MW = 23;
  localparam int SW = MW + 5;
  localparam int NV = 16;
  localparam int NW = 300;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [EW+1:0] in_exp;
  logic [SW-1:0] in_sig;
  logic [31:0] out_result;
  logic [3:0] out_flags;

  int checks = 0;
  int failures = 0;
  int acc = 0;
  int del = 0;
  bit mon_en = 0;
  bit hold_v = 0;
  logic [35:0] hold_val, cur_exp;
  logic [35:0] exp_q[$];

  typedef struct {
    logic          sign;
    logic [EW+1:0] exp;
    logic [SW-1:0] sig;
    logic [31:0]   res;
    logic [3:0]    flg;
  } vec_t;
  vec_t vecs[NV];

  fp_normalize_round #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  // Exact round-to-nearest-even of the significand to MW+1 bits, then range classification.
  function automatic logic [35:0] ref_model(input logic s, input logic [EW+1:0] e_raw, input logic [SW-1:0] sg);
    longint sig, q, rem, half;
    int p, e, sh;
    logic inx;
    logic [31:0] r;
    sig = longint'(sg);
    if (sg == '0) return {s, 31'd0, 4'b0001};
    p = 0;
    while ((sig >> (p + 1)) != 0) p++;
    e = int'($signed(e_raw)) + p - (SW - 2);
    inx = 1'b0;
    if (p > MW) begin
      sh = p - MW;
      q = sig >> sh;
      rem = sig - (q << sh);
      half = longint'(1) << (sh - 1);
      inx = rem != 0;
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else q = sig << (MW - p);
    if (e <= 0) return {s, 31'd0, 4'b0111};
    if (q == (longint'(1) << (MW + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= (1 << EW) - 1) return {s, {EW{1'b1}}, {MW{1'b0}}, 4'b1010};
    r = {s, e[EW-1:0], q[MW-1:0]};
    return {r, 2'b00, inx, 1'b0};
  endfunction

  task automatic step(input bit bp);
    @(posedge clk);
    #1;
    if (bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_vec(input logic s, input logic [EW+1:0] e, input logic [SW-1:0] sg,
                         input logic [31:0] res, input logic [3:0] flg, input string id);
    chk({id, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = sg;
    step(0);
    in_valid = 1'b0;
    in_sig = SW'($urandom);
    chk({id, "_valid_early"}, out_valid, 1'b0);
    step(0);
    chk({id, "_valid"}, out_valid, 1'b1);
    chk({id, "_result"}, out_result, res);
    chk({id, "_flags"}, out_flags, flg);
  endtask

  task automatic send(input logic s, input logic [EW+1:0] e, input logic [SW-1:0] sg);
    int w;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = sg;
    cur_exp = ref_model(s, e, sg);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 64) begin
      step(1);
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout waited=%0d", w);
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic rnd_word(output logic s, output logic [EW+1:0] e, output logic [SW-1:0] sg);
    logic [SW-1:0] m;
    m = '1;
    m = m >> $urandom_range(0, SW - 1);
    sg = SW'($urandom) & m;
    if ($urandom_range(0, 3) == 0) sg[SW-1] = 1'b1;
    if ($urandom_range(0, 15) == 0) sg = '0;
    s = 1'($urandom_range(0, 1));
    e = ($urandom_range(0, 7) == 0) ? (EW+2)'($urandom) : (EW+2)'($urandom_range(0, 290)) - (EW+2)'(10);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("in_ready_occ", in_ready, !((acc - del) == 2 && !out_ready));
      if (hold_v) chk("stall_stable", {out_valid, out_result, out_flags}, {1'b1, hold_val});
      hold_v = out_valid && !out_ready;
      hold_val = {out_result, out_flags};
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc++;
      end
      if (out_valid && out_ready) begin
        del++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra got=%h", {out_result, out_flags});
        end else chk("stream_word", {out_result, out_flags}, exp_q.pop_front());
      end
    end else hold_v = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    logic [EW+1:0] e;
    logic [SW-1:0] sg;
    logic [35:0] m;
    vecs[0]  = '{1'b0, 10'd127,  28'h4000000, 32'h3F800000, 4'b0000};
    vecs[1]  = '{1'b0, 10'd127,  28'h8000000, 32'h40000000, 4'b0000};
    vecs[2]  = '{1'b0, 10'd127,  28'h0000008, 32'h34000000, 4'b0000};
    vecs[3]  = '{1'b1, 10'd127,  28'h0000000, 32'h80000000, 4'b0001};
    vecs[4]  = '{1'b0, 10'd127,  28'h4000004, 32'h3F800000, 4'b0010};
    vecs[5]  = '{1'b0, 10'd127,  28'h400000C, 32'h3F800002, 4'b0010};
    vecs[6]  = '{1'b0, 10'd127,  28'h7FFFFFC, 32'h40000000, 4'b0010};
    vecs[7]  = '{1'b0, 10'd254,  28'h8000000, 32'h7F800000, 4'b1010};
    vecs[8]  = '{1'b0, 10'd1,    28'h2000000, 32'h00000000, 4'b0111};
    vecs[9]  = '{1'b1, 10'd127,  28'h4000000, 32'hBF800000, 4'b0000};
    vecs[10] = '{1'b0, 10'd0,    28'h8000000, 32'h00800000, 4'b0000};
    vecs[11] = '{1'b0, 10'd254,  28'h7FFFFFC, 32'h7F800000, 4'b1010};
    vecs[12] = '{1'b1, 10'd1,    28'h7FFFFFC, 32'h81000000, 4'b0010};
    vecs[13] = '{1'b0, 10'h3FB,  28'h8000000, 32'h00000000, 4'b0111};
    vecs[14] = '{1'b0, 10'd127,  28'h8000001, 32'h40000000, 4'b0010};
    vecs[15] = '{1'b0, 10'd127,  28'h8000018, 32'h40000002, 4'b0010};

    rst = 1'b1; in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd127; in_sig = 28'h4000000; out_ready = 1'b1;
    step(0);
    step(0);
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", out_result, 32'h0);
    chk("reset_flags", out_flags, 4'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    step(0);
    chk("reset_no_capture", out_valid, 1'b0);

    for (int i = 0; i < NV; i++)
      run_vec(vecs[i].sign, vecs[i].exp, vecs[i].sig, vecs[i].res, vecs[i].flg, $sformatf("vec%0d", i));
    step(0);
    chk("directed_drained", out_valid, 1'b0);

    mon_en = 1;
    for (int n = 0; n < NW; n++) begin
      rnd_word(s, e, sg);
      send(s, e, sg);
      if ($urandom_range(0, 3) == 0) step(1);
    end
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) step(1);
    chk("drain_empty", exp_q.size(), 0);
    chk("delivered", del, NW);
    mon_en = 0;

    out_ready = 1'b0;
    step(0);
    rnd_word(s, e, sg);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = sg;
    step(0);
    rnd_word(s, e, sg);
    in_sign = s; in_exp = e; in_sig = sg;
    step(0);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", out_result, 32'h0);
    chk("midrst_flags", out_flags, 4'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    s = 1'b1; e = 10'd130; sg = 28'h5A5A5A4;
    m = ref_model(s, e, sg);
    run_vec(s, e, sg, m[35:4], m[3:0], "post_rst");
    step(0);
    chk("post_rst_gone1", out_valid, 1'b0);
    step(0);
    chk("post_rst_gone2", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
